data_mem_resp: RTL
==================

# data_mem_resp

Data-side memory responder for the RISC-V core. It serves the load/store path from the execute stage using the same req/gnt/rvalid handshake that the fetch stage uses toward instruction memory, but adds writes with byte enables. It holds a word-addressed data array and returns read data or write acknowledges in order, after a fixed pipelined latency. It is used in simulation benches and as the behavioural reference for the eventual SRAM macro wrapper.

## Interface

Parameters:
- DEPTH_WORDS, 8192: number of 32-bit words; valid word index 0..DEPTH_WORDS-1.
- LATENCY, 1: cycles from grant to rvalid; legal range 1..4.
- LFSR_SEED, 8'hA5: initial value of the stall LFSR (used only with the Configuration macro).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-low.
- data_req_in  input  1  request valid from initiator.
- data_addr_in  input  32  byte address; bits [1:0] ignored.
- data_we_in  input  1  1 = write, 0 = read.
- data_be_in  input  4  byte enables for writes; bit i covers byte i (bits 8i+7:8i).
- data_wdata_in  input  32  write data.
- data_gnt_o  output  1  request accepted this cycle (combinational).
- data_rvalid_o  output  1  response valid, one cycle per granted request.
- data_rdata_o  output  32  read data; 0 for writes and errors.
- data_err_o  output  1  response is for an out-of-range address.

## Operation

- Grant: data_gnt_o = data_req_in and not stall. A transfer occurs when req and gnt are both high at a rising edge. One transfer per cycle maximum. There is no backpressure on responses.
- Word index: data_addr_in[31:2]. If the index is >= DEPTH_WORDS, the access is in error: no write occurs, rdata is 0, and err is 1.
- Write: at the transfer edge, each byte with be[i]=1 is updated from wdata. Bytes with be[i]=0 are unchanged. be=0000 is a legal no-op write and still gets a response.
- Read: the array is sampled at the transfer edge. The sampled value travels through the response pipeline.
- Response pipeline: a LATENCY-stage shift register carrying {valid, rdata, err}. Stage 0 is loaded at each transfer edge. Outputs are driven from the last stage. Responses come back strictly in request order.
- Ordering: a read granted one cycle after a write to the same word returns the written data.
- Array contents are not reset. Uninitialised words read as X in simulation.
- Reset mid-operation: every pipeline stage is cleared and in-flight responses are dropped. No rvalid is produced for requests granted before reset.

## Timing

- Reset values: data_rvalid_o=0, data_rdata_o=0, data_err_o=0. data_gnt_o follows data_req_in (0 when req is 0). The LFSR is loaded with LFSR_SEED.
- Latency: a transfer at edge n gives data_rvalid_o=1 during the cycle after edge n+LATENCY-1. With LATENCY=1, rvalid is high for the cycle immediately following the transfer edge.
- Throughput: back-to-back transfers give consecutive rvalid cycles. Up to LATENCY responses can be outstanding.
- data_rvalid_o is high for exactly one cycle per transfer. data_rdata_o and data_err_o are 0 whenever rvalid is 0.
- Request signals are only sampled at edges where gnt=1. The initiator must hold addr/we/be/wdata stable while req=1 and gnt=0.

## Configuration

- DATA_MEM_LFSR_STALL_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle when out of reset.
  - stall = lfsr[0], so grants are denied pseudo-randomly.
  - The LFSR never reaches 0 from a nonzero seed.
  - A seed of 0 is replaced by 8'h01.
- DATA_MEM_LFSR_STALL_EN undefined:
  - stall is tied to 0 and gnt = req.
  - No LFSR logic is present.

## Test plan

- Basic write then read (LATENCY=1): write 32'hDEADBEEF to addr 0x10 with be=1111. Expect rvalid the next cycle with rdata=0 and err=0. Then read 0x10; expect rdata=32'hDEADBEEF one cycle after its grant.
- Byte enables: after the basic write, write 32'h0000AA00 to 0x10 with be=0010. Read 0x10 and expect 32'hDEADAAEF. A be=0000 write leaves the word unchanged.
- Out-of-range access: with DEPTH_WORDS=8192, write to addr 0x8000. Expect a response with err=1 and rdata=0. A following read of 0x0 returns its previous value, confirming no aliasing.
- Pipelining (LATENCY=3): four back-to-back reads of 0x0, 0x4, 0x8, 0xC, preloaded with 1, 2, 3, 4. Expect rvalid high for 4 consecutive cycles starting 3 cycles after the first grant, with rdata 1, 2, 3, 4 in order.
- Reset mid-flight (LATENCY=3): grant two reads, then pull reset low for one cycle before their responses. Expect rvalid to stay 0 for the following 5 cycles. A new request after reset completes normally.
- Stall build (macro defined, seed 8'hA5): hold req high for 64 cycles with incrementing addresses. Expect gnt low at least once, exactly one rvalid per grant, in-order data, and no lost or duplicated response.

Source files
------------

// File: rtl/data_mem_resp.sv
// data_mem_resp: word-addressed data memory responder for the load/store path.
// Uses a req/gnt/rvalid handshake with byte-enabled writes. Responses return in
// order after LATENCY cycles through a shift-register pipeline.
// Define DATA_MEM_LFSR_STALL_EN to deny grants pseudo-randomly from an 8-bit LFSR.
module data_mem_resp #(
    parameter int unsigned DEPTH_WORDS = 8192,
    parameter int unsigned LATENCY     = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req_in,
    input  logic [31:0] data_addr_in,
    input  logic        data_we_in,
    input  logic [3:0]  data_be_in,
    input  logic [31:0] data_wdata_in,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic          stall;
    logic          xfer;
    logic [29:0]   word_idx;
    logic          in_range;
    logic [AW-1:0] mem_idx;
    logic [31:0]   rd_word;

    // Contents are intentionally not reset.
    logic [31:0] mem [DEPTH_WORDS];

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] err_q;
    logic [31:0]        rdata_q [LATENCY];

    assign data_gnt_o = data_req_in & ~stall;
    assign xfer       = data_req_in & data_gnt_o;
    assign word_idx   = data_addr_in[31:2];
    assign in_range   = ({2'b00, word_idx} < DEPTH_WORDS);
    assign mem_idx    = word_idx[AW-1:0];

    // Sample the array at the transfer edge; writes and errors respond with zero data.
    always_comb begin
        rd_word = '0;
        if (xfer && !data_we_in && in_range) begin
            rd_word = mem[mem_idx];
        end
    end

    // Byte-enabled write; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (xfer && data_we_in && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (data_be_in[i]) begin
                    mem[mem_idx][8*i +: 8] <= data_wdata_in[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 loads each edge, later stages shift; reset drops in-flight work.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= xfer;
            err_q[0]   <= xfer & ~in_range;
            rdata_q[0] <= rd_word;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    assign data_rvalid_o = valid_q[LATENCY-1];
    assign data_err_o    = err_q[LATENCY-1];
    assign data_rdata_o  = rdata_q[LATENCY-1];

`ifdef DATA_MEM_LFSR_STALL_EN
    // A zero seed would lock the LFSR, so substitute 1.
    localparam logic [7:0] lfsr_init = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Fibonacci step, polynomial x^8 + x^6 + x^5 + x^4 + 1.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR state advances every cycle out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= lfsr_init;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = lfsr_q[0];

    logic unused_addr;
    assign unused_addr = ^data_addr_in[1:0];
`else
    assign stall = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^{data_addr_in[1:0], LFSR_SEED};
`endif

endmodule
